// File: rtl/rca_share_arbiter_pkg.sv
// Shared definitions for the two-requester adder-sharing arbiter.
package rca_share_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

    // Requester 1 counts as the last winner out of reset, so requester 0 wins first.
    localparam req_id_t RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/rca_share_arbiter_rca.sv
// Plain ripple-carry adder used as the shared datapath.
module rca_share_arbiter_rca #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic            i_cin,
    output logic [BITS-1:0] o_sum,
    output logic            o_cout
);

    logic [BITS:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar k = 0; k < BITS; k++) begin : g_fa
        assign o_sum[k]       = i_a[k] ^ i_b[k] ^ w_carry[k];
        assign w_carry[k+1]   = (i_a[k] & i_b[k]) | (w_carry[k] & (i_a[k] ^ i_b[k]));
    end

    assign o_cout = w_carry[BITS];

endmodule

// File: rtl/rca_share_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant plus the last-winner register.
module rr_arbiter2
    import rca_share_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_elig,
    output logic [NUM_REQ-1:0] o_grant
);

    req_id_t r_last_grant;

    // No grant is issued in a reset cycle, so nothing is accepted then.
    always_comb begin
        o_grant = '0;
        if (!i_rst) begin
            case (i_elig)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= RR_RESET_LAST;
        end else if (o_grant[0]) begin
            r_last_grant <= 1'b0;
        end else if (o_grant[1]) begin
            r_last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/rca_share_arbiter.sv
// One ripple-carry adder shared round-robin between two requesters,
// each with a registered response slot.
module rca_share_arbiter
    import rca_share_arbiter_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*BITS-1:0] req_a,
    input  logic [NUM_REQ*BITS-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_cin,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [NUM_REQ*BITS-1:0] resp_sum,
    output logic [NUM_REQ-1:0]      resp_cout
);

    logic [NUM_REQ-1:0]            w_elig;
    logic [NUM_REQ-1:0]            w_grant;
    logic                          w_sel;
    logic [BITS-1:0]               w_add_a;
    logic [BITS-1:0]               w_add_b;
    logic                          w_add_cin;
    logic [BITS-1:0]               w_sum;
    logic                          w_cout;

    logic [NUM_REQ-1:0][BITS-1:0]  r_sum;
    logic [NUM_REQ-1:0]            r_cout;
    logic [NUM_REQ-1:0]            r_valid;

    // A slot being drained this cycle can be refilled this cycle.
    assign w_elig = req_valid & (~r_valid | resp_ready);

    rr_arbiter2 u_arb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_elig  (w_elig),
        .o_grant (w_grant)
    );

    assign w_sel = w_grant[1];

    // Adder inputs held at zero when idle to keep the carry chain quiet.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        if (|w_grant) begin
            w_add_a   = w_sel ? req_a[BITS +: BITS] : req_a[0 +: BITS];
            w_add_b   = w_sel ? req_b[BITS +: BITS] : req_b[0 +: BITS];
            w_add_cin = req_cin[w_sel];
        end
    end

    rca_share_arbiter_rca #(.BITS(BITS)) u_rca (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_sum[i]   <= w_sum;
                    r_cout[i]  <= w_cout;
                    r_valid[i] <= 1'b1;
                end else if (resp_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign resp_valid = r_valid;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed plus randomized bench for rca_share_arbiter against an arithmetic reference model.
module tb_rca_share_arbiter;

    localparam int BITS = 8;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*BITS-1:0] req_a;
    logic [2*BITS-1:0] req_b;
    logic [1:0]        req_cin;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [2*BITS-1:0] resp_sum;
    logic [1:0]        resp_cout;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [1:0]      m_vld;
    logic [BITS-1:0] m_sum [2];
    logic [1:0]      m_cout;
    int              m_last;
    logic [1:0]      obs_rdy;

    rca_share_arbiter #(.BITS(BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic [1:0] rr, input logic r);
        logic [1:0] e;
        if (r) return 2'b00;
        e = v & (~m_vld | rr);
        if (e == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return e;
    endfunction

    task automatic step(input logic [1:0] v, input logic [1:0] rr,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] cin, input logic r);
        logic [1:0] g;
        int t;
        @(negedge clk);
        req_valid  = v;
        resp_ready = rr;
        req_a      = a;
        req_b      = b;
        req_cin    = cin;
        rst        = r;
        #1;
        g = exp_grant(v, rr, r);
        obs_rdy = req_ready;
        chk("req_ready", {30'd0, req_ready}, {30'd0, g});
        @(posedge clk);
        if (r) begin
            m_vld = 2'b00; m_sum[0] = '0; m_sum[1] = '0; m_cout = 2'b00; m_last = 1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    t = int'(i == 0 ? a[7:0] : a[15:8]) + int'(i == 0 ? b[7:0] : b[15:8]) + int'(cin[i]);
                    m_sum[i]  = t[7:0];
                    m_cout[i] = t[8];
                    m_vld[i]  = 1'b1;
                    m_last    = i;
                end else if (rr[i] && m_vld[i]) begin
                    m_vld[i] = 1'b0;
                end
            end
        end
        #1;
        chk("resp_valid", {30'd0, resp_valid}, {30'd0, m_vld});
        chk("resp_sum",   {16'd0, resp_sum},   {16'd0, m_sum[1], m_sum[0]});
        chk("resp_cout",  {30'd0, resp_cout},  {30'd0, m_cout});
    endtask

    initial begin
        req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_cin = '0; rst = 1'b1;
        m_vld = 2'b00; m_sum[0] = '0; m_sum[1] = '0; m_cout = 2'b00; m_last = 1; obs_rdy = '0;

        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        step(2'b11, 2'b00, 16'h1234, 16'h5678, 2'b11, 1'b1);
        chk("rst_ready", {30'd0, obs_rdy}, 32'h0);

        // idle after reset release
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
            chk("idle_valid", {30'd0, resp_valid}, 32'h0);
            chk("idle_sum", {16'd0, resp_sum}, 32'h0);
        end

        // single requester 0
        step(2'b01, 2'b00, 16'h007F, 16'h0001, 2'b00, 1'b0);
        chk("r0_ready", {30'd0, obs_rdy}, 32'h1);
        chk("r0_sum", {24'd0, resp_sum[7:0]}, 32'h80);
        chk("r0_cout", {31'd0, resp_cout[0]}, 32'h0);

        // alternation from a fresh reset
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        step(2'b11, 2'b11, 16'hFF03, 16'h0104, 2'b10, 1'b0);
        chk("alt0", {30'd0, obs_rdy}, 32'h1);
        step(2'b11, 2'b11, 16'hFF03, 16'h0104, 2'b10, 1'b0);
        chk("alt1", {30'd0, obs_rdy}, 32'h2);
        chk("alt_sum1", {24'd0, resp_sum[15:8]}, 32'h01);
        chk("alt_cout1", {31'd0, resp_cout[1]}, 32'h1);
        step(2'b11, 2'b11, 16'hFF03, 16'h0104, 2'b10, 1'b0);
        chk("alt2", {30'd0, obs_rdy}, 32'h1);
        step(2'b11, 2'b11, 16'hFF03, 16'h0104, 2'b10, 1'b0);
        chk("alt3", {30'd0, obs_rdy}, 32'h2);

        // slot 0 stalled: requester 1 takes every cycle, slot 0 holds
        step(2'b01, 2'b10, 16'h0011, 16'h0022, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 2'b10, 16'h5566, 16'h0102, 2'b00, 1'b0);
            chk("stall_ready", {30'd0, obs_rdy}, 32'h2);
            chk("stall_sum0", {24'd0, resp_sum[7:0]}, 32'h33);
            chk("stall_vld0", {31'd0, resp_valid[0]}, 32'h1);
        end
        step(2'b11, 2'b11, 16'h5566, 16'h0102, 2'b00, 1'b0);
        chk("drain_grant", {30'd0, obs_rdy}, 32'h1);

        // back-to-back on requester 0
        for (int k = 1; k <= 3; k++) begin
            step(2'b01, 2'b01, 16'(k), 16'(k), 2'b00, 1'b0);
            chk("b2b_sum", {24'd0, resp_sum[7:0]}, 32'(2 * k));
            chk("b2b_vld", {31'd0, resp_valid[0]}, 32'h1);
        end

        // reset mid-operation with both slots full
        step(2'b11, 2'b00, 16'h0909, 16'h0101, 2'b00, 1'b0);
        step(2'b11, 2'b00, 16'h0909, 16'h0101, 2'b00, 1'b0);
        chk("full_both", {30'd0, resp_valid}, 32'h3);
        step(2'b11, 2'b00, 16'h0909, 16'h0101, 2'b00, 1'b1);
        chk("mid_rst_vld", {30'd0, resp_valid}, 32'h0);
        step(2'b11, 2'b00, 16'h0909, 16'h0101, 2'b00, 1'b0);
        chk("post_rst_grant", {30'd0, obs_rdy}, 32'h1);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                 2'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
